// File: rtl/beat_sequencer.sv
// Per-beat controller for the spiking ECG classifier: runs one arbitration window per
// heartbeat, logs the outcome into a show-ahead result FIFO and keeps per-class beat counts.
module beat_sequencer #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               beat_start,
    input  logic               spike_any,
    input  logic [1:0]         class_in,
    input  logic               timer_done,
    output logic               arb_load,
    output logic               arb_run,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [1:0]         res_class,
    output logic               res_timeout,
    output logic [LVL_W-1:0]   res_level,
    input  logic               cnt_clr,
    output logic [4*CNT_W-1:0] class_cnt,
    output logic               dropped
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_PUSH = 2'd3;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [1:0]       lat_class;
    logic             lat_timeout;
    logic [1:0]       fifo_class [DEPTH];
    logic             fifo_tmo   [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [LVL_W-1:0] level;
    logic [CNT_W-1:0] cnt [4];
    logic             pop;
    logic             push_req;
    logic             push;

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (beat_start) state_nxt = ST_LOAD;
            ST_LOAD: state_nxt = ST_RUN;
            ST_RUN:  if (spike_any || timer_done) state_nxt = ST_PUSH;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) state <= ST_IDLE;
        else         state <= state_nxt;
    end

    // Decision latch: a spike wins over a coincident timeout. Never reset; PUSH is only
    // reachable through a fresh RUN decision, so a stale value is never written.
    always_ff @(posedge clk) begin
        if (state == ST_RUN) begin
            if (spike_any)       {lat_timeout, lat_class} <= {1'b0, class_in};
            else if (timer_done) {lat_timeout, lat_class} <= {1'b1, 2'b00};
        end
    end

    assign arb_load  = (state == ST_LOAD);
    assign arb_run   = (state == ST_RUN);
    assign busy      = (state != ST_IDLE);
    assign push_req  = (state == ST_PUSH);
    assign res_valid = (level != '0);
    assign pop       = res_valid && res_ready;
    assign push      = push_req && ((level != FULL_LVL) || pop);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_class[wr_ptr] <= lat_class;
            fifo_tmo[wr_ptr]   <= lat_timeout;
        end
    end

    assign res_class   = res_valid ? fifo_class[rd_ptr] : 2'b00;
    assign res_timeout = res_valid ? fifo_tmo[rd_ptr]   : 1'b0;
    assign res_level   = level;

    // Counters count every decided beat, including ones the FIFO had to drop
    always_ff @(posedge clk) begin
        if (!resetn || cnt_clr) begin
            for (int k = 0; k < 4; k++) cnt[k] <= '0;
            dropped <= 1'b0;
        end else if (push_req) begin
            if (cnt[lat_class] != '1) cnt[lat_class] <= cnt[lat_class] + 1'b1;
            if (!push) dropped <= 1'b1;
        end
    end

    always_comb begin
        class_cnt = '0;
        for (int k = 0; k < 4; k++) class_cnt[k*CNT_W +: CNT_W] = cnt[k];
    end

endmodule

// File: tb/tb_beat_sequencer.sv
// Directed self-checking bench for beat_sequencer (DEPTH=8, CNT_W=16).
module tb_beat_sequencer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 16;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic               clk = 1'b0;
    logic               resetn;
    logic               beat_start;
    logic               spike_any;
    logic [1:0]         class_in;
    logic               timer_done;
    logic               arb_load;
    logic               arb_run;
    logic               busy;
    logic               res_valid;
    logic               res_ready;
    logic [1:0]         res_class;
    logic               res_timeout;
    logic [LVL_W-1:0]   res_level;
    logic               cnt_clr;
    logic [4*CNT_W-1:0] class_cnt;
    logic               dropped;

    int checks   = 0;
    int failures = 0;

    beat_sequencer #(.DEPTH(DEPTH), .CNT_W(CNT_W), .LVL_W(LVL_W)) dut (
        .clk(clk), .resetn(resetn), .beat_start(beat_start), .spike_any(spike_any),
        .class_in(class_in), .timer_done(timer_done), .arb_load(arb_load),
        .arb_run(arb_run), .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_class(res_class), .res_timeout(res_timeout), .res_level(res_level),
        .cnt_clr(cnt_clr), .class_cnt(class_cnt), .dropped(dropped)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [CNT_W-1:0] cnt_of(input int k);
        return class_cnt[k*CNT_W +: CNT_W];
    endfunction

    // One full beat; the decision is presented in the nrun-th RUN cycle. Ends in IDLE.
    task automatic beat(input logic spk, input logic [1:0] cls, input logic tmo,
                        input int nrun, input logic rdy_push, output int runs);
        runs = 0;
        beat_start = 1'b1;
        tick();
        beat_start = 1'b0;
        for (int i = 0; i < nrun; i++) begin
            tick();
            if (arb_run) runs++;
            if (i == nrun - 1) begin
                spike_any  = spk;
                class_in   = cls;
                timer_done = tmo;
            end
        end
        tick();
        if (arb_run) runs++;
        spike_any  = 1'b0;
        timer_done = 1'b0;
        res_ready  = rdy_push;
        tick();
        res_ready  = 1'b0;
    endtask

    task automatic pop_one();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        int runs;
        int loads;
        logic [1:0] ovf_cls [9];
        logic [1:0] after_cls [8];
        ovf_cls   = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
        after_cls = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd3};

        resetn = 1'b0; beat_start = 1'b0; spike_any = 1'b0; class_in = 2'd0;
        timer_done = 1'b0; res_ready = 1'b0; cnt_clr = 1'b0;
        tick(); tick();
        chk("rst_busy",  busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_level", res_level, 0);
        chk("rst_class", res_class, 0);
        chk("rst_cnt",   class_cnt[31:0] | class_cnt[63:32], 0);
        chk("rst_drop",  dropped, 0);
        resetn = 1'b1;
        tick();

        // Basic beat: spike class 2 in the first RUN cycle
        beat_start = 1'b1;
        tick();
        beat_start = 1'b0;
        chk("t1_load",  arb_load, 1);
        chk("t1_run0",  arb_run, 0);
        chk("t1_busy",  busy, 1);
        tick();
        chk("t2_load",  arb_load, 0);
        chk("t2_run",   arb_run, 1);
        spike_any = 1'b1; class_in = 2'd2;
        tick();
        spike_any = 1'b0;
        chk("t3_run",   arb_run, 0);
        chk("t3_busy",  busy, 1);
        chk("t3_valid", res_valid, 0);
        tick();
        chk("t4_valid", res_valid, 1);
        chk("t4_class", res_class, 2);
        chk("t4_tmo",   res_timeout, 0);
        chk("t4_cnt2",  cnt_of(2), 1);
        chk("t4_level", res_level, 1);
        chk("t4_busy",  busy, 0);
        pop_one();
        chk("pop1_valid", res_valid, 0);

        // Timeout in the 5th RUN cycle
        beat(1'b0, 2'd3, 1'b1, 5, 1'b0, runs);
        chk("tmo_runs",  runs, 5);
        chk("tmo_valid", res_valid, 1);
        chk("tmo_flag",  res_timeout, 1);
        chk("tmo_class", res_class, 0);
        chk("tmo_cnt0",  cnt_of(0), 1);
        pop_one();

        // Spike and timer_done together: spike wins
        beat(1'b1, 2'd3, 1'b1, 1, 1'b0, runs);
        chk("coin_class", res_class, 3);
        chk("coin_tmo",   res_timeout, 0);
        chk("coin_level", res_level, 1);
        chk("coin_cnt3",  cnt_of(3), 1);
        chk("coin_cnt0",  cnt_of(0), 1);
        pop_one();
        chk("coin_empty", res_level, 0);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_cnt", class_cnt[31:0] | class_cnt[63:32], 0);

        // Overflow: 9 beats into an 8-entry FIFO with no consumer
        for (int i = 0; i < 9; i++) beat(1'b1, ovf_cls[i], 1'b0, 1, 1'b0, runs);
        chk("ovf_level", res_level, 8);
        chk("ovf_drop",  dropped, 1);
        chk("ovf_c0",    cnt_of(0), 1);
        chk("ovf_c1",    cnt_of(1), 3);
        chk("ovf_c2",    cnt_of(2), 3);
        chk("ovf_c3",    cnt_of(3), 2);
        chk("ovf_total", cnt_of(0) + cnt_of(1) + cnt_of(2) + cnt_of(3), 9);
        chk("ovf_head",  res_class, 1);

        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("ovf_clr_drop", dropped, 0);
        // Push while full with a concurrent pop of the head
        beat(1'b1, 2'd3, 1'b0, 1, 1'b1, runs);
        chk("pp_level", res_level, 8);
        chk("pp_drop",  dropped, 0);
        chk("pp_cnt3",  cnt_of(3), 1);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain_valid%0d", i), res_valid, 1);
            chk($sformatf("drain_class%0d", i), res_class, after_cls[i]);
            pop_one();
        end
        chk("drain_empty", res_valid, 0);
        chk("drain_level", res_level, 0);

        // beat_start held high: one load every 4 cycles, clear during every PUSH
        beat_start = 1'b1; spike_any = 1'b1; class_in = 2'd1;
        loads = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (arb_load) loads++;
            cnt_clr = busy && !arb_load && !arb_run;
        end
        beat_start = 1'b0; spike_any = 1'b0; cnt_clr = 1'b0;
        tick();
        chk("hold_loads", loads, 3);
        chk("hold_cnt1",  cnt_of(1), 0);
        chk("hold_level", res_level, 3);
        chk("hold_class", res_class, 1);
        for (int i = 0; i < 3; i++) pop_one();

        // Reset in the middle of a window with three entries queued
        beat(1'b0, 2'd0, 1'b1, 2, 1'b0, runs);
        beat(1'b1, 2'd2, 1'b0, 1, 1'b0, runs);
        beat(1'b1, 2'd3, 1'b0, 3, 1'b0, runs);
        chk("pre_level", res_level, 3);
        chk("pre_cnt2",  cnt_of(2), 1);
        beat_start = 1'b1;
        tick();
        beat_start = 1'b0;
        tick();
        chk("pre_run", arb_run, 1);
        resetn = 1'b0; spike_any = 1'b1; class_in = 2'd2;
        tick();
        resetn = 1'b1; spike_any = 1'b0;
        chk("mid_valid", res_valid, 0);
        chk("mid_level", res_level, 0);
        chk("mid_busy",  busy, 0);
        chk("mid_run",   arb_run, 0);
        chk("mid_cnt",   class_cnt[31:0] | class_cnt[63:32], 0);
        tick(); tick();
        chk("post_valid", res_valid, 0);
        chk("post_cnt",   class_cnt[31:0] | class_cnt[63:32], 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/beat_sequencer.md
# beat_sequencer

Per-beat controller and result buffer for the spiking ECG classifier. For each heartbeat it starts one arbitration window on the output-layer arbiter and waits for either the first decoded class or a window timeout. It then logs the outcome into a small show-ahead FIFO and updates per-class beat counters. It sits directly downstream of the output-spike arbiter and upstream of the host/readout interface.

## Interface
- DEPTH, 8, result FIFO entries; power of 2, ≥2
- CNT_W, 16, width of each per-class beat counter
- LVL_W, $clog2(DEPTH)+1, width of res_level
- clk  in  1  clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- beat_start  in  1  request classification of a new beat; honoured only in IDLE
- spike_any  in  1  any output-layer spike this cycle (arbiter decision present)
- class_in  in  2  arbiter class code; meaningful when spike_any=1
- timer_done  in  1  arbitration window elapsed
- arb_load  out  1  one-cycle pulse: reload window timer / clear network state
- arb_run  out  1  window timer enable; high throughout RUN
- busy  out  1  high in every state except IDLE
- res_valid  out  1  FIFO non-empty
- res_ready  in  1  consumer accepts head entry
- res_class  out  2  head entry class; 0 when empty
- res_timeout  out  1  head entry was a timeout; 0 when empty
- res_level  out  LVL_W  FIFO occupancy, 0..DEPTH
- cnt_clr  in  1  synchronous clear of counters and dropped
- class_cnt  out  4*CNT_W  counters; class k at bits [k*CNT_W +: CNT_W]
- dropped  out  1  sticky: a result was lost to a full FIFO

## Operation
- FSM states: IDLE, LOAD, RUN, PUSH.
  - IDLE: if beat_start, go to LOAD; otherwise stay.
  - LOAD: arb_load=1 for exactly this cycle; go to RUN.
  - RUN: arb_run=1.
    - If spike_any, latch {timeout=0, class=class_in} and go to PUSH.
    - Else if timer_done, latch {timeout=1, class=0} and go to PUSH.
    - Else stay in RUN.
    - spike_any has priority when it coincides with timer_done.
  - PUSH: write the latched entry to the FIFO, then return to IDLE unconditionally.
- Write acceptance in PUSH:
  - Write if res_level<DEPTH, or if a pop occurs in the same cycle.
  - Otherwise discard the entry and set dropped.
- Counters in PUSH:
  - class_cnt[latched class] increments whether or not the FIFO write succeeds; timeouts count under class 0.
  - Counters saturate at all-ones and never wrap.
- beat_start outside IDLE is ignored, not queued.
- FIFO behaviour:
  - Show-ahead: res_class/res_timeout reflect the head entry combinationally from storage.
  - Pop on res_valid & res_ready; res_ready while empty has no effect.
  - Pointers wrap modulo DEPTH.
- cnt_clr zeroes all counters and dropped. If it coincides with an increment or a drop, the clear wins. It does not affect the FSM or the FIFO.
- Reset (resetn=0 at a clock edge), including mid-window: state=IDLE, FIFO empty, counters 0, dropped 0. All outputs read 0 in the following cycle. Any latched entry is discarded.

## Timing
- beat_start sampled high at edge t (IDLE) → LOAD during cycle t+1 (arb_load=1) → RUN from cycle t+2.
- Decision sampled in RUN at edge r → PUSH during cycle r+1 → FIFO write and counter update visible from cycle r+2.
  - res_valid rises in cycle r+2 if the FIFO was empty.
- Minimum beat period: 4 cycles (IDLE, LOAD, one RUN cycle, PUSH). beat_start is accepted again in the cycle after PUSH.
- busy rises the cycle after beat_start is accepted and falls in the cycle after PUSH.
- Pop: entry removed at the edge where res_valid&res_ready; next entry (or empty) visible in the next cycle.
- res_level updates one cycle after push/pop. Simultaneous push+pop leaves it unchanged.

## Test plan
- Reset → beat_start at t, spike_any=1 with class_in=2 in the first RUN cycle:
  - arb_load at t+1 only; arb_run only at t+2.
  - res_valid=1, res_class=2, res_timeout=0, class_cnt[2]=1 from t+4.
- Timeout → no spike, timer_done=1 in the 5th RUN cycle → entry {timeout=1, class=0}; class_cnt[0]=1; arb_run high for exactly 5 cycles.
- Coincidence → spike_any=1, class_in=3 and timer_done=1 in the same cycle → entry {0,3}; no timeout entry.
- Overflow → 9 beats with res_ready=0, DEPTH=8:
  - res_level=8 and dropped=1.
  - The class counters total 9.
  - Popping returns the first 8 classes in order.
  - A push with a concurrent pop while full is accepted and dropped does not set.
- Ignored start → beat_start held high continuously → exactly one arb_load per 4 cycles; cnt_clr during PUSH leaves that counter at 0.
- Reset mid-RUN with 3 entries queued → next cycle: res_valid=0, res_level=0, busy=0, counters 0; no entry written for the aborted beat.
